// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM state encoding.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// One-bit full-adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/ripple_digit.sv
// DIGIT-bit ripple-carry chain of fa cells; exposes the carry into and out of the top bit
// so the caller can derive signed overflow on the final digit.
module ripple_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             c_top,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0]  = ci;
  assign co    = c[DIGIT];
  assign c_top = c[DIGIT-1];

  for (genvar g = 0; g < DIGIT; g++) begin : g_bit
    fa u_fa (
      .a  (a[g]),
      .b  (b[g]),
      .ci (c[g]),
      .s  (s[g]),
      .co (c[g+1])
    );
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per clock, LSB digit first.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] da, db, ds;
  logic             c_top, c_out;
  logic             last;

  // Select the current digit of the captured operands; constant slices keep the mux simple.
  always_comb begin
    da = '0;
    db = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        da = a_q[k*DIGIT +: DIGIT];
        db = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  assign last = (cnt == CW'(N - 1));

  ripple_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (da),
    .b     (db),
    .ci    (carry),
    .s     (ds),
    .c_top (c_top),
    .co    (c_out)
  );

  // Next-state logic; DONE lasts one cycle unless start chains straight into RUN.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Operand capture, per-digit sum/carry update and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (state != RUN && start) begin
        a_q   <= A;
        b_q   <= B;
        carry <= Cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        for (int k = 0; k < N; k++)
          if (cnt == CW'(k)) Sum[k*DIGIT +: DIGIT] <= ds;
        carry <= c_out;
        cnt   <= cnt + CW'(1);
        if (last) begin
          Cout <= c_out;
          ovf  <= c_top ^ c_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench: four serial_adder instances (DIGIT = 1, 2, 4, 8) on a shared clock/reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       st1 = 0, st2 = 0, st4 = 0, st8 = 0;

  logic [7:0] sum1, sum2, sum4, sum8;
  logic       co1, co2, co4, co8;
  logic       ov1, ov2, ov4, ov8;
  logic       bz1, bz2, bz4, bz8;
  logic       dn1, dn2, dn4, dn8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a), .B(b), .Cin(cin),
    .Sum(sum1), .Cout(co1), .ovf(ov1), .busy(bz1), .done(dn1));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .A(a), .B(b), .Cin(cin),
    .Sum(sum2), .Cout(co2), .ovf(ov2), .busy(bz2), .done(dn2));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .A(a), .B(b), .Cin(cin),
    .Sum(sum4), .Cout(co4), .ovf(ov4), .busy(bz4), .done(dn4));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .A(a), .B(b), .Cin(cin),
    .Sum(sum8), .Cout(co8), .ovf(ov8), .busy(bz8), .done(dn8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         ndone;
    logic [7:0] dsum;
    logic       dco, dov;

    // Reset state
    #2;
    chk("rst_sum1", sum1, 8'h00);
    chk("rst_flags1", {co1, ov1, bz1, dn1}, 4'b0000);
    chk("rst_flags8", {co8, ov8, bz8, dn8}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // DIGIT=1: 7F + 01 -> 80, signed overflow; busy for 8 cycles
    a = 8'h7F; b = 8'h01; cin = 1'b0; st1 = 1;
    tick();                                   // E0
    st1 = 0;
    chk("t1_busy_e0", {bz1, dn1}, 2'b10);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t1_busy_e%0d", i), {bz1, dn1}, 2'b10);
    end
    tick();                                   // E8
    chk("t1_done", {bz1, dn1}, 2'b01);
    chk("t1_sum", sum1, 8'h80);
    chk("t1_cout_ovf", {co1, ov1}, 2'b01);
    tick();
    chk("t1_done_1cyc", {bz1, dn1}, 2'b00);
    chk("t1_sum_hold", sum1, 8'h80);

    // DIGIT=2: FF + 01 + 1 -> 01, carry out, no overflow
    a = 8'hFF; b = 8'h01; cin = 1'b1; st2 = 1;
    tick();                                   // E0
    st2 = 0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("t2_wait_e%0d", i), {bz2, dn2}, 2'b10);
    end
    tick();                                   // E4
    chk("t2_done", dn2, 1'b1);
    chk("t2_sum", sum2, 8'h01);
    chk("t2_cout_ovf", {co2, ov2}, 2'b10);

    // DIGIT=8: A5 + 5A -> FF, finished at E1
    a = 8'hA5; b = 8'h5A; cin = 1'b0; st8 = 1;
    tick();                                   // E0
    st8 = 0;
    chk("t3_busy", {bz8, dn8}, 2'b10);
    tick();                                   // E1
    chk("t3_done", {bz8, dn8}, 2'b01);
    chk("t3_sum", sum8, 8'hFF);
    chk("t3_cout_ovf", {co8, ov8}, 2'b00);

    // DIGIT=1: start held while busy, operands change mid-run
    a = 8'h3C; b = 8'h0F; cin = 1'b1; st1 = 1;
    tick();                                   // E0
    tick();                                   // E1
    tick();                                   // E2
    chk("t4_busy", bz1, 1'b1);
    chk("t4_ovf_hold", {co1, ov1}, 2'b01);
    a = 8'h00; b = 8'hFF; cin = 1'b0; st1 = 0;
    tick();                                   // E3
    tick();                                   // E4
    chk("t4_partial", sum1, 8'h8C);
    ndone = 0; dsum = '0; dco = 1'bx; dov = 1'bx;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dn1) begin
        ndone++;
        dsum = sum1; dco = co1; dov = ov1;
      end
    end
    chk("t4_one_done", ndone, 1);
    chk("t4_sum", dsum, 8'h4C);
    chk("t4_cout_ovf", {dco, dov}, 2'b00);

    // DIGIT=4: start held across DONE -> back-to-back, pulses 3 cycles apart
    a = 8'h12; b = 8'h34; cin = 1'b0; st4 = 1;
    tick();                                   // E0
    a = 8'h01; b = 8'h01;
    tick();                                   // E1
    chk("t5_e1", {bz4, dn4}, 2'b10);
    tick();                                   // E2
    chk("t5_done1", {bz4, dn4}, 2'b01);
    chk("t5_sum1", sum4, 8'h46);
    tick();                                   // E3: restart, no IDLE
    st4 = 0;
    chk("t5_restart", {bz4, dn4}, 2'b10);
    tick();                                   // E4
    chk("t5_e4", {bz4, dn4}, 2'b10);
    tick();                                   // E5
    chk("t5_done2", {bz4, dn4}, 2'b01);
    chk("t5_sum2", sum4, 8'h02);

    // DIGIT=1: asynchronous reset mid-run
    tick();
    a = 8'h55; b = 8'h11; cin = 1'b0; st1 = 1;
    tick();                                   // E0
    st1 = 0;
    for (int i = 1; i <= 4; i++) tick();      // E1..E4
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_sum", sum1, 8'h00);
    chk("t6_async_flags", {co1, ov1, bz1, dn1}, 4'b0000);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dn1 || bz1) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h01; b = 8'h02; cin = 1'b0; st1 = 1;
    tick();                                   // first edge after release
    st1 = 0;
    chk("t6_restart_busy", bz1, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (dn1) ndone++;
    end
    chk("t6_no_stray_done", ndone, 0);
    tick();                                   // E8
    chk("t6_done", dn1, 1'b1);
    chk("t6_sum", sum1, 8'h03);
    chk("t6_cout_ovf", {co1, ov1}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
